hs4_bd_rx: RTL and testbench
============================

Name: hs4_bd_rx

Overview:
- Clocked receiver for the 4-phase bundled-data handshake that our C2-based asynchronous pipelines drive.
- Sits at the async-to-sync boundary: it accepts tokens from an async stage (req/data in, ack out), buffers them, and presents them to clocked logic as a valid/ready stream.
- It is the consumer end of the async producer built from the cell library.

Parameters:
- DATA_W, 8: width of the bundled data word.
- SYNC_STAGES, 2: flop stages synchronising req_i (minimum 2).
- FIFO_DEPTH, 2: token buffer entries (power of 2, minimum 2).

Ports:
- clk  input  1  single clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
- req_i  input  1  4-phase request from the async producer (asynchronous to clk).
- data_i  input  DATA_W  bundled data; stable from req_i rise until ack_o rise.
- ack_o  output  1  4-phase acknowledge to the producer, registered.
- m_valid_o  output  1  buffered token available.
- m_ready_i  input  1  consumer accepts the head token.
- m_data_o  output  DATA_W  head token data.
- full_o  output  1  FIFO holds FIFO_DEPTH tokens.

Behaviour:
- Reset (async assert, sync deassert by clk): ack_o=0, m_valid_o=0, m_data_o=0, full_o=0. The synchroniser chain clears to 0, the FIFO empties, and the FSM goes to IDLE.
- Synchroniser: req_i passes through SYNC_STAGES flops to give req_s. data_i is never synchronised; the bundling constraint plus the synchroniser delay guarantees it is stable when sampled.
- FSM states:
  - IDLE (ack_o=0):
    - req_s=1 and full_o=0: push data_i into the FIFO, go to ACK.
    - req_s=1 and full_o=1: hold in IDLE and withhold ack (backpressure).
  - ACK (ack_o=1): wait for req_s=0, then go to IDLE. ack_o falls on the cycle after req_s is seen low.
- ack_o is a flop driven from the next-state logic. It rises in the same cycle the pushed token becomes visible.
- Latency, with the FIFO not full:
  - req_i rise to ack_o rise: SYNC_STAGES+1 clk edges.
  - req_i fall to ack_o fall: SYNC_STAGES+1 edges.
  - Full handshake cycle: at least 2*(SYNC_STAGES+1) cycles per token.
- FIFO:
  - Read and write pointers are clog2(FIFO_DEPTH)+1 bits, wrapping naturally.
  - full = (MSBs differ, LSBs equal); empty = pointers equal.
- FIFO output side:
  - m_valid_o = !empty, m_data_o = mem[rd].
  - Pop when m_valid_o && m_ready_i.
- Simultaneous push and pop:
  - Not full: both happen, occupancy unchanged.
  - Full: push is gated by the registered full_o, so the pop happens and the push is retried next cycle.
- Exactly one push per handshake. In ACK, req_s staying high causes no further pushes.
- Stream rule: m_data_o is stable while m_valid_o=1 && m_ready_i=0.
- Reset mid-handshake: ack_o drops immediately and buffered tokens are discarded. If req_i is still high after release, the token is re-captured as new; the producer completes normally.
- Glitches on req_i shorter than one clk are not part of the protocol. Behaviour under such glitches is undefined but must never push twice without an intervening req_s=0.

Decomposition:
- hs4_pkg holds the FSM state enum (HS4_IDLE, HS4_ACK) and the minimum-value constants for SYNC_STAGES and FIFO_DEPTH.
- One sub-module: hs4_sync, a SYNC_STAGES-deep async-reset synchroniser, reused later by the transmitter.
- The FIFO stays inline.

Test Plan:
- Single token: reset, drive data_i=0xA5, raise req_i with m_ready_i=1 -> ack_o rises 3 edges later, m_valid_o=1 with m_data_o=0xA5 for 1 cycle; drop req_i -> ack_o falls 3 edges later.
- Backpressure: m_ready_i=0, send tokens 0x01,0x02,0x03 -> first two acked, full_o=1. Third req_i holds ack_o=0 until one pop, then ack rises 1 cycle after full_o clears. Read order is 0x01,0x02,0x03.
- Simultaneous push and pop at occupancy 1: push and pop in the same cycle -> occupancy stays 1, no token lost or duplicated.
- Long req: hold req_i high 50 cycles -> exactly one push, ack_o stays 1 until req falls.
- Reset mid-handshake: assert rst_n=0 while in ACK with 2 buffered tokens -> ack_o=0 and m_valid_o=0 immediately. Release with req_i high -> one new token captured, ack_o=1 after SYNC_STAGES+1 edges.
- Throughput: 16 back-to-back tokens with m_ready_i=1 and a zero-delay producer model -> all received in order, no gaps beyond 2*(SYNC_STAGES+1) cycles per token.

Source files
------------

// File: rtl/hs4_pkg.sv
// Shared types and limits for the 4-phase bundled-data
// receiver/transmitter pair.
package hs4_pkg;

   typedef enum logic {
      HS4_IDLE,
      HS4_ACK
   } hs4_state_e;

   localparam int HS4_MIN_SYNC  = 2;
   localparam int HS4_MIN_DEPTH = 2;

endpackage

// File: rtl/hs4_sync.sv
// Multi-flop synchroniser with async active-low reset,
// shared by the bundled-data receiver and transmitter.
module hs4_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff <= '0;
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/hs4_bd_rx.sv
// 4-phase bundled-data receiver: async req/ack in,
// buffered valid/ready stream out.
module hs4_bd_rx
   import hs4_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              ack_o,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [DATA_W-1:0] m_data_o,
   output logic              full_o
);

   localparam int AW = $clog2(FIFO_DEPTH);

   if (SYNC_STAGES < HS4_MIN_SYNC) begin : g_bad_sync
      $error("hs4_bd_rx: SYNC_STAGES too small");
   end
   if (FIFO_DEPTH < HS4_MIN_DEPTH) begin : g_bad_depth
      $error("hs4_bd_rx: FIFO_DEPTH too small");
   end

   hs4_state_e        state;
   logic              req_s;
   logic [AW:0]       wptr;
   logic [AW:0]       rptr;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic              empty;
   logic              full;
   logic              push;
   logic              pop;

   hs4_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (req_i),
      .q     (req_s)
   );

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);

   // Only IDLE may push, so one token per req_s high phase.
   assign push = (state == HS4_IDLE) && req_s && !full;
   assign pop  = !empty && m_ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= HS4_IDLE;
         ack_o <= 1'b0;
         wptr  <= '0;
         rptr  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         unique case (state)
            HS4_IDLE: begin
               if (push) begin
                  state <= HS4_ACK;
                  ack_o <= 1'b1;
               end
            end
            HS4_ACK: begin
               if (!req_s) begin
                  state <= HS4_IDLE;
                  ack_o <= 1'b0;
               end
            end
            default: begin
               state <= HS4_IDLE;
               ack_o <= 1'b0;
            end
         endcase
         if (push) begin
            mem[wptr[AW-1:0]] <= data_i;
            wptr              <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
      end
   end

   assign m_valid_o = !empty;
   assign m_data_o  = mem[rptr[AW-1:0]];
   assign full_o    = full;

endmodule

// File: tb/tb_hs4_bd_rx.sv
// Directed bench for hs4_bd_rx with a token scoreboard
// checked on every stream handshake.
module tb_hs4_bd_rx;

   logic       clk;
   logic       rst_n;
   logic       req_i;
   logic [7:0] data_i;
   logic       ack_o;
   logic       m_valid_o;
   logic       m_ready_i;
   logic [7:0] m_data_o;
   logic       full_o;

   int         tests;
   int         fails;
   int         cyc;
   logic [7:0] sb[$];

   hs4_bd_rx #(
      .DATA_W      (8),
      .SYNC_STAGES (2),
      .FIFO_DEPTH  (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req_i),
      .data_i    (data_i),
      .ack_o     (ack_o),
      .m_valid_o (m_valid_o),
      .m_ready_i (m_ready_i),
      .m_data_o  (m_data_o),
      .full_o    (full_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Stream monitor: a token leaves at the next edge when valid&ready.
   always begin
      @(negedge clk);
      #1;
      if (rst_n && m_valid_o && m_ready_i) begin
         chk("sb_nonempty", sb.size() > 0, 1);
         if (sb.size() > 0) chk("stream_data", m_data_o, sb.pop_front());
      end
   end

   task automatic wait_ack(input logic lvl, output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (ack_o !== lvl && n < 200);
      chk("ack_reached", ack_o, lvl);
   endtask

   task automatic send(input logic [7:0] d,
                       output int rise, output int fall);
      @(negedge clk);
      data_i = d;
      sb.push_back(d);
      req_i = 1'b1;
      wait_ack(1'b1, rise);
      @(negedge clk);
      req_i = 1'b0;
      wait_ack(1'b0, fall);
   endtask

   task automatic drain;
      @(negedge clk);
      m_ready_i = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("drained", m_valid_o, 1'b0);
   endtask

   initial begin
      int r;
      int f;
      int t0;
      tests = 0;
      fails = 0;
      cyc   = 0;
      rst_n = 1'b0;
      req_i = 1'b0;
      data_i = 8'h00;
      m_ready_i = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_ack", ack_o, 1'b0);
      chk("rst_valid", m_valid_o, 1'b0);
      chk("rst_data", m_data_o, 8'h00);
      chk("rst_full", full_o, 1'b0);
      rst_n = 1'b1;

      // single token with latency
      @(negedge clk);
      m_ready_i = 1'b1;
      data_i = 8'hA5;
      sb.push_back(8'hA5);
      req_i = 1'b1;
      wait_ack(1'b1, r);
      chk("single_rise_lat", r, 3);
      chk("single_valid", m_valid_o, 1'b1);
      chk("single_data", m_data_o, 8'hA5);
      @(posedge clk);
      #1;
      chk("single_one_cycle", m_valid_o, 1'b0);
      @(negedge clk);
      req_i = 1'b0;
      wait_ack(1'b0, f);
      chk("single_fall_lat", f, 3);

      // backpressure
      @(negedge clk);
      m_ready_i = 1'b0;
      send(8'h01, r, f);
      chk("bp_rise1", r, 3);
      send(8'h02, r, f);
      chk("bp_rise2", r, 3);
      chk("bp_full", full_o, 1'b1);
      @(negedge clk);
      data_i = 8'h03;
      sb.push_back(8'h03);
      req_i = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("bp_ack_held", ack_o, 1'b0);
      chk("bp_head_stable", m_data_o, 8'h01);
      @(negedge clk);
      m_ready_i = 1'b1;
      @(negedge clk);
      m_ready_i = 1'b0;
      chk("bp_full_clear", full_o, 1'b0);
      wait_ack(1'b1, r);
      chk("bp_ack_after_pop", r, 1);
      chk("bp_full_again", full_o, 1'b1);
      @(negedge clk);
      req_i = 1'b0;
      wait_ack(1'b0, f);
      chk("bp_fall_lat", f, 3);
      drain();

      // simultaneous push and pop at occupancy 1
      @(negedge clk);
      m_ready_i = 1'b0;
      send(8'h11, r, f);
      @(negedge clk);
      data_i = 8'h22;
      sb.push_back(8'h22);
      req_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      m_ready_i = 1'b1;
      @(posedge clk);
      #1;
      chk("pp_ack", ack_o, 1'b1);
      chk("pp_valid", m_valid_o, 1'b1);
      chk("pp_data", m_data_o, 8'h22);
      chk("pp_not_full", full_o, 1'b0);
      @(negedge clk);
      m_ready_i = 1'b0;
      req_i = 1'b0;
      wait_ack(1'b0, f);
      drain();

      // long request: one push only
      @(negedge clk);
      m_ready_i = 1'b0;
      data_i = 8'h5A;
      sb.push_back(8'h5A);
      req_i = 1'b1;
      wait_ack(1'b1, r);
      repeat (50) @(posedge clk);
      #1;
      chk("long_ack_high", ack_o, 1'b1);
      chk("long_valid", m_valid_o, 1'b1);
      chk("long_one_push", full_o, 1'b0);
      @(negedge clk);
      req_i = 1'b0;
      wait_ack(1'b0, f);

      // reset mid-handshake with two buffered tokens
      @(negedge clk);
      data_i = 8'h6B;
      req_i = 1'b1;
      wait_ack(1'b1, r);
      chk("mid_full", full_o, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ack", ack_o, 1'b0);
      chk("mid_rst_valid", m_valid_o, 1'b0);
      chk("mid_rst_full", full_o, 1'b0);
      sb.delete();
      sb.push_back(8'h6B);
      @(negedge clk);
      rst_n = 1'b1;
      wait_ack(1'b1, r);
      chk("mid_recap_lat", r, 3);
      chk("mid_recap_data", m_data_o, 8'h6B);
      chk("mid_recap_once", full_o, 1'b0);
      @(negedge clk);
      req_i = 1'b0;
      wait_ack(1'b0, f);
      drain();

      // throughput: 16 back-to-back tokens
      t0 = cyc;
      for (int i = 0; i < 16; i++) begin
         send(8'h80 + 8'(i * 7), r, f);
         chk("tp_rise", r, 3);
         chk("tp_fall", f, 3);
      end
      chk("tp_cycles", (cyc - t0) <= 16 * 6, 1);
      repeat (4) @(posedge clk);
      #1;
      chk("tp_all_received", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
